// File: rtl/jac_control_unit.sv
// Jac1-8 instruction sequencer: fetch/decode/execute FSM, 8x8 register file,
// ALU operand staging and program-flow resolution against status and registers.
module jac_control_unit #(
    parameter int DataWidth     = 8,
    parameter int NumOpCodeBits = 5,
    parameter int ParamBits     = 8,
    parameter int NumStatusBits = 3,
    parameter int NumRegs       = 8
) (
    input  logic                                                  clock,
    input  logic                                                  reset,
    input  logic                                                  run,
    output logic                                                  imem_req,
    output logic [ParamBits-1:0]                                  imem_addr,
    input  logic [NumOpCodeBits+$clog2(NumRegs)+ParamBits-1:0]    imem_data,
    input  logic                                                  imem_valid,
    output logic [NumOpCodeBits-1:0]                              alu_opcode,
    output logic [DataWidth-1:0]                                  alu_operand1,
    output logic [DataWidth-1:0]                                  alu_operand2,
    output logic [ParamBits-1:0]                                  alu_param,
    input  logic [DataWidth-1:0]                                  alu_result,
    input  logic [NumStatusBits-1:0]                              alu_status,
    output logic [NumStatusBits-1:0]                              status_q,
    output logic [ParamBits-1:0]                                  pc,
    output logic                                                  instr_retired,
    output logic                                                  illegal_op,
    input  logic [$clog2(NumRegs)-1:0]                            dbg_sel,
    output logic [DataWidth-1:0]                                  dbg_data
);

    localparam int RegIdxBits = $clog2(NumRegs);
    localparam int InstrBits  = NumOpCodeBits + RegIdxBits + ParamBits;
    localparam int ZeroBit    = 2;

    localparam logic [NumOpCodeBits-1:0] OP_NOP  = NumOpCodeBits'(5'b00000);
    localparam logic [NumOpCodeBits-1:0] OP_ADD  = NumOpCodeBits'(5'b00001);
    localparam logic [NumOpCodeBits-1:0] OP_SUB  = NumOpCodeBits'(5'b00010);
    localparam logic [NumOpCodeBits-1:0] OP_AND  = NumOpCodeBits'(5'b00011);
    localparam logic [NumOpCodeBits-1:0] OP_OR   = NumOpCodeBits'(5'b00100);
    localparam logic [NumOpCodeBits-1:0] OP_NOT  = NumOpCodeBits'(5'b00101);
    localparam logic [NumOpCodeBits-1:0] OP_XOR  = NumOpCodeBits'(5'b00110);
    localparam logic [NumOpCodeBits-1:0] OP_SHL  = NumOpCodeBits'(5'b00111);
    localparam logic [NumOpCodeBits-1:0] OP_SHR  = NumOpCodeBits'(5'b01000);
    localparam logic [NumOpCodeBits-1:0] OP_VAL  = NumOpCodeBits'(5'b01001);
    localparam logic [NumOpCodeBits-1:0] OP_GOTO = NumOpCodeBits'(5'b10000);
    localparam logic [NumOpCodeBits-1:0] OP_IFZ  = NumOpCodeBits'(5'b10001);
    localparam logic [NumOpCodeBits-1:0] OP_IFNZ = NumOpCodeBits'(5'b10010);
    localparam logic [NumOpCodeBits-1:0] OP_IFEQ = NumOpCodeBits'(5'b10011);
    localparam logic [NumOpCodeBits-1:0] OP_IFST = NumOpCodeBits'(5'b10100);
    localparam logic [NumOpCodeBits-1:0] OP_IFGT = NumOpCodeBits'(5'b10101);

    typedef enum logic [1:0] {S_FETCH, S_DECODE, S_EXECUTE} state_e;

    state_e                     r_state;
    state_e                     w_next_state;
    logic                       w_fetch_fire;
    logic [InstrBits-1:0]       r_instr;
    logic [ParamBits-1:0]       r_pc;
    logic [NumStatusBits-1:0]   r_status;
    logic [DataWidth-1:0]       r_regs [NumRegs];
    logic [NumOpCodeBits-1:0]   r_alu_opcode;
    logic [DataWidth-1:0]       r_alu_operand1;
    logic [DataWidth-1:0]       r_alu_operand2;
    logic [ParamBits-1:0]       r_alu_param;

    logic [NumOpCodeBits-1:0]   w_opcode;
    logic [RegIdxBits-1:0]      w_rd;
    logic [ParamBits-1:0]       w_param;
    logic [DataWidth-1:0]       w_rd_val;
    logic [DataWidth-1:0]       w_r0_val;
    logic                       w_branch;
    logic                       w_wr_reg;
    logic                       w_wr_status;
    logic                       w_illegal;
    logic [DataWidth-1:0]       w_wr_data;
    logic [ParamBits-1:0]       w_pc_next;

    assign w_opcode = r_instr[InstrBits-1 -: NumOpCodeBits];
    assign w_rd     = r_instr[ParamBits +: RegIdxBits];
    assign w_param  = r_instr[ParamBits-1:0];
    assign w_rd_val = r_regs[w_rd];
    assign w_r0_val = r_regs[0];

    // NOTE: state and datapath registers use non-blocking assignments so every
    // flop samples pre-edge values regardless of statement order.
    always_ff @(posedge clock) begin
        if (reset) r_state <= S_FETCH;
        else       r_state <= w_next_state;
    end

    // NOTE: every combinational output gets a default first so no path leaves
    // a signal unassigned and infers a latch.
    always_comb begin
        w_next_state = r_state;
        imem_req     = 1'b0;
        w_fetch_fire = 1'b0;
        case (r_state)
            S_FETCH: begin
                // Reset gates the request so a pending fetch is dropped immediately.
                imem_req     = run & ~reset;
                w_fetch_fire = run & ~reset & imem_valid;
                if (w_fetch_fire) w_next_state = S_DECODE;
            end
            S_DECODE:  w_next_state = S_EXECUTE;
            S_EXECUTE: w_next_state = S_FETCH;
            default:   w_next_state = S_FETCH;
        endcase
    end

    always_comb begin
        w_branch    = 1'b0;
        w_wr_reg    = 1'b0;
        w_wr_status = 1'b0;
        w_illegal   = 1'b0;
        w_wr_data   = alu_result;
        case (w_opcode)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_NOT, OP_XOR, OP_SHL, OP_SHR: begin
                w_wr_reg    = 1'b1;
                w_wr_status = 1'b1;
            end
            OP_VAL: begin
                w_wr_reg  = 1'b1;
                w_wr_data = DataWidth'(w_param);
            end
            OP_NOP:  ;
            OP_GOTO: w_branch = 1'b1;
            OP_IFZ:  w_branch = r_status[ZeroBit];
            OP_IFNZ: w_branch = ~r_status[ZeroBit];
            OP_IFEQ: w_branch = (w_rd_val == w_r0_val);
            OP_IFST: w_branch = (w_rd_val <  w_r0_val);
            OP_IFGT: w_branch = (w_rd_val >  w_r0_val);
            default: w_illegal = 1'b1;
        endcase
        w_pc_next = w_branch ? w_param : r_pc + ParamBits'(1);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_instr        <= '0;
            r_pc           <= '0;
            r_status       <= '0;
            r_alu_opcode   <= '0;
            r_alu_operand1 <= '0;
            r_alu_operand2 <= '0;
            r_alu_param    <= '0;
            // NOTE: the register file is architecturally cleared by reset, so it
            // is built from resettable flops rather than an inferred RAM.
            for (int i = 0; i < NumRegs; i++) r_regs[i] <= '0;
        end else begin
            if (w_fetch_fire) r_instr <= imem_data;
            if (r_state == S_DECODE) begin
                r_alu_opcode   <= w_opcode;
                r_alu_operand1 <= w_rd_val;
                r_alu_operand2 <= r_regs[w_param[RegIdxBits-1:0]];
                r_alu_param    <= w_param;
            end
            if (r_state == S_EXECUTE) begin
                r_pc <= w_pc_next;
                if (w_wr_reg)    r_regs[w_rd] <= w_wr_data;
                if (w_wr_status) r_status     <= alu_status;
            end
        end
    end

    assign imem_addr     = r_pc;
    assign pc            = r_pc;
    assign status_q      = r_status;
    assign alu_opcode    = r_alu_opcode;
    assign alu_operand1  = r_alu_operand1;
    assign alu_operand2  = r_alu_operand2;
    assign alu_param     = r_alu_param;
    assign instr_retired = (r_state == S_EXECUTE);
    assign illegal_op    = (r_state == S_EXECUTE) & w_illegal;
    assign dbg_data      = r_regs[dbg_sel];

endmodule

// File: tb/tb_jac_control_unit.sv
// Self-checking bench for jac_control_unit: behavioural ALU and program memory,
// a table of short programs with hand-computed results, plus timing sequences.
module tb_jac_control_unit;

    localparam logic [4:0] NOP  = 5'b00000;
    localparam logic [4:0] ADD  = 5'b00001;
    localparam logic [4:0] SUB  = 5'b00010;
    localparam logic [4:0] ANDI = 5'b00011;
    localparam logic [4:0] ORI  = 5'b00100;
    localparam logic [4:0] NOTI = 5'b00101;
    localparam logic [4:0] XORI = 5'b00110;
    localparam logic [4:0] SHL  = 5'b00111;
    localparam logic [4:0] SHR  = 5'b01000;
    localparam logic [4:0] VAL  = 5'b01001;
    localparam logic [4:0] GOTO = 5'b10000;
    localparam logic [4:0] IFZ  = 5'b10001;
    localparam logic [4:0] IFNZ = 5'b10010;
    localparam logic [4:0] IFEQ = 5'b10011;
    localparam logic [4:0] IFST = 5'b10100;
    localparam logic [4:0] IFGT = 5'b10101;
    localparam logic [4:0] ILL  = 5'b01010;

    logic        clock, reset, run;
    logic        imem_req, imem_valid;
    logic [7:0]  imem_addr;
    logic [15:0] imem_data;
    logic [4:0]  alu_opcode;
    logic [7:0]  alu_operand1, alu_operand2, alu_param, alu_result;
    logic [2:0]  alu_status, status_q;
    logic [7:0]  pc;
    logic        instr_retired, illegal_op;
    logic [2:0]  dbg_sel;
    logic [7:0]  dbg_data;

    logic [15:0] mem [256];
    logic        auto_valid, manual_valid;
    int          n_pass, n_total, n_ill_seen, n_ill_orphan;

    jac_control_unit dut (
        .clock(clock), .reset(reset), .run(run),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_data(imem_data),
        .imem_valid(imem_valid),
        .alu_opcode(alu_opcode), .alu_operand1(alu_operand1),
        .alu_operand2(alu_operand2), .alu_param(alu_param),
        .alu_result(alu_result), .alu_status(alu_status),
        .status_q(status_q), .pc(pc),
        .instr_retired(instr_retired), .illegal_op(illegal_op),
        .dbg_sel(dbg_sel), .dbg_data(dbg_data)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    assign imem_data  = mem[imem_addr];
    assign imem_valid = (auto_valid & imem_req) | manual_valid;

    // Reference ALU: status = {zero, underflow, carry}.
    logic [8:0] alu_wide;
    logic       alu_c, alu_u;
    always_comb begin
        alu_wide = 9'd0;
        alu_c    = 1'b0;
        alu_u    = 1'b0;
        case (alu_opcode)
            ADD:  alu_wide = {1'b0, alu_operand1} + {1'b0, alu_operand2};
            SUB: begin
                alu_wide = {1'b0, alu_operand1 - alu_operand2};
                alu_u    = alu_operand1 < alu_operand2;
            end
            ANDI: alu_wide = {1'b0, alu_operand1 & alu_operand2};
            ORI:  alu_wide = {1'b0, alu_operand1 | alu_operand2};
            NOTI: alu_wide = {1'b0, ~alu_operand1};
            XORI: alu_wide = {1'b0, alu_operand1 ^ alu_operand2};
            SHL:  alu_wide = {alu_operand1, 1'b0};
            SHR:  alu_wide = {alu_operand1[0], 1'b0, alu_operand1[7:1]};
            default: alu_wide = 9'd0;
        endcase
        alu_c      = alu_wide[8];
        alu_result = alu_wide[7:0];
        alu_status = {alu_result == 8'd0, alu_u, alu_c};
    end

    always @(negedge clock) begin
        if (illegal_op) begin
            n_ill_seen++;
            if (!instr_retired) n_ill_orphan++;
        end
    end

    typedef struct {
        int               n;
        logic [3:0][15:0] prog;
        logic [2:0]       reg_sel;
        logic [7:0]       exp_reg;
        logic [2:0]       exp_status;
        logic [7:0]       exp_pc;
        int               exp_illegal;
    } vec_t;

    vec_t vecs [10];

    function automatic logic [15:0] enc(input logic [4:0] op, input logic [2:0] rd,
                                        input logic [7:0] p);
        return {op, rd, p};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        else             n_pass++;
    endtask

    task automatic set_vec(input int idx, input int n, input logic [15:0] p0,
                           input logic [15:0] p1, input logic [15:0] p2, input logic [15:0] p3,
                           input logic [2:0] rs, input logic [7:0] er, input logic [2:0] es,
                           input logic [7:0] ep, input int ei);
        vecs[idx].n           = n;
        vecs[idx].prog[0]     = p0;
        vecs[idx].prog[1]     = p1;
        vecs[idx].prog[2]     = p2;
        vecs[idx].prog[3]     = p3;
        vecs[idx].reg_sel     = rs;
        vecs[idx].exp_reg     = er;
        vecs[idx].exp_status  = es;
        vecs[idx].exp_pc      = ep;
        vecs[idx].exp_illegal = ei;
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        run   = 1'b0;
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic wait_retire(output int cycles);
        bit found;
        found  = 1'b0;
        cycles = 0;
        while (!found && cycles < 30) begin
            @(negedge clock);
            cycles++;
            if (instr_retired) found = 1'b1;
        end
        if (!found) check("retire_timeout", 32'(cycles), 32'd0);
    endtask

    task automatic peek_reg(input logic [2:0] r, output logic [7:0] v);
        dbg_sel = r;
        #1;
        v = dbg_data;
    endtask

    int          c;
    logic [7:0]  rv;

    initial begin
        n_pass = 0; n_total = 0; n_ill_seen = 0; n_ill_orphan = 0;
        reset = 1'b1; run = 1'b0; auto_valid = 1'b1; manual_valid = 1'b0; dbg_sel = 3'd0;
        clear_mem();

        set_vec(0, 3, enc(VAL,1,8'd5), enc(VAL,2,8'd3), enc(ADD,1,8'd2), 16'h0, 3'd1, 8'h08, 3'b000, 8'h03, 0);
        set_vec(1, 3, enc(VAL,3,8'h0F), enc(VAL,4,8'hF0), enc(ANDI,3,8'd4), 16'h0, 3'd3, 8'h00, 3'b100, 8'h03, 0);
        set_vec(2, 4, enc(VAL,3,8'h0F), enc(VAL,4,8'hF0), enc(ANDI,3,8'd4), enc(IFZ,0,8'h40), 3'd3, 8'h00, 3'b100, 8'h40, 0);
        set_vec(3, 3, enc(VAL,0,8'd7), enc(VAL,5,8'd7), enc(IFEQ,5,8'h20), 16'h0, 3'd5, 8'h07, 3'b000, 8'h20, 0);
        set_vec(4, 3, enc(VAL,0,8'd7), enc(VAL,5,8'd9), enc(IFGT,5,8'h30), 16'h0, 3'd5, 8'h09, 3'b000, 8'h30, 0);
        set_vec(5, 3, enc(VAL,0,8'd7), enc(VAL,5,8'd9), enc(IFST,5,8'h50), 16'h0, 3'd5, 8'h09, 3'b000, 8'h03, 0);
        set_vec(6, 2, enc(VAL,6,8'hAA), enc(ILL,6,8'h11), 16'h0, 16'h0, 3'd6, 8'hAA, 3'b000, 8'h02, 1);
        set_vec(7, 2, enc(VAL,1,8'd1), enc(IFNZ,0,8'h10), 16'h0, 16'h0, 3'd1, 8'h01, 3'b000, 8'h10, 0);
        set_vec(8, 3, enc(VAL,1,8'd3), enc(VAL,2,8'd5), enc(SUB,1,8'd2), 16'h0, 3'd1, 8'hFE, 3'b010, 8'h03, 0);
        set_vec(9, 2, enc(VAL,7,8'h81), enc(ADD,7,8'd7), 16'h0, 16'h0, 3'd7, 8'h02, 3'b001, 8'h02, 0);

        @(negedge clock);
        do_reset();

        // Table of short programs loaded at address 0.
        for (int v = 0; v < 10; v++) begin
            clear_mem();
            for (int j = 0; j < 4; j++) mem[j] = vecs[v].prog[j];
            do_reset();
            n_ill_seen = 0;
            run = 1'b1;
            for (int k = 0; k < vecs[v].n; k++) wait_retire(c);
            run = 1'b0;
            @(negedge clock);
            peek_reg(vecs[v].reg_sel, rv);
            check($sformatf("vec%0d_reg", v), 32'(rv), 32'(vecs[v].exp_reg));
            check($sformatf("vec%0d_status", v), 32'(status_q), 32'(vecs[v].exp_status));
            check($sformatf("vec%0d_pc", v), 32'(pc), 32'(vecs[v].exp_pc));
            check($sformatf("vec%0d_illegal", v), 32'(n_ill_seen), 32'(vecs[v].exp_illegal));
        end

        // Reset clears everything, including a non-zero register file; run=1 is masked.
        reset = 1'b1;
        run   = 1'b1;
        @(negedge clock);
        check("rst_pc", 32'(pc), 32'd0);
        check("rst_status", 32'(status_q), 32'd0);
        check("rst_imem_req", 32'(imem_req), 32'd0);
        check("rst_alu", {alu_opcode, alu_operand1, alu_operand2, alu_param[2:0]}, 32'd0);
        check("rst_retired", 32'(instr_retired), 32'd0);
        check("rst_illegal", 32'(illegal_op), 32'd0);
        for (int r = 0; r < 8; r++) begin
            peek_reg(3'(r), rv);
            check($sformatf("rst_r%0d", r), 32'(rv), 32'd0);
        end
        run   = 1'b0;
        reset = 1'b0;

        // Retire cadence, staged ALU operands and debug-read timing.
        clear_mem();
        mem[0] = enc(VAL,1,8'd5); mem[1] = enc(VAL,2,8'd3); mem[2] = enc(ADD,1,8'd2);
        do_reset();
        dbg_sel = 3'd1;
        run = 1'b1;
        wait_retire(c);
        wait_retire(c);
        check("gap_1", 32'(c), 32'd3);
        wait_retire(c);
        check("gap_2", 32'(c), 32'd3);
        check("exec_alu_opcode", 32'(alu_opcode), 32'(ADD));
        check("exec_operands", {16'd0, alu_operand1, alu_operand2}, {16'd0, 8'd5, 8'd3});
        check("exec_param", 32'(alu_param), 32'd2);
        check("dbg_before_commit", 32'(dbg_data), 32'd5);
        run = 1'b0;
        @(negedge clock);
        check("dbg_after_commit", 32'(dbg_data), 32'd8);
        check("retired_one_cycle", 32'(instr_retired), 32'd0);

        // Illegal opcode pulses together with retire for exactly one cycle.
        clear_mem();
        mem[0] = enc(VAL,6,8'hAA); mem[1] = enc(ILL,6,8'h11);
        do_reset();
        run = 1'b1;
        wait_retire(c);
        wait_retire(c);
        check("ill_pulse", {30'd0, illegal_op, instr_retired}, 32'b11);
        run = 1'b0;
        @(negedge clock);
        check("ill_pulse_end", 32'(illegal_op), 32'd0);

        // IFZ taken, then IFNZ at the target falls through.
        clear_mem();
        mem[0] = enc(VAL,3,8'h0F); mem[1] = enc(VAL,4,8'hF0); mem[2] = enc(ANDI,3,8'd4);
        mem[3] = enc(IFZ,0,8'h40); mem[8'h40] = enc(IFNZ,0,8'h10);
        do_reset();
        run = 1'b1;
        for (int k = 0; k < 4; k++) wait_retire(c);
        @(negedge clock);
        check("ifz_pc", 32'(pc), 32'h40);
        wait_retire(c);
        run = 1'b0;
        @(negedge clock);
        check("ifnz_pc", 32'(pc), 32'h41);
        check("ifnz_status", 32'(status_q), 32'b100);

        // GOTO 0xFF then NOP wraps pc to 0.
        clear_mem();
        mem[0] = enc(GOTO,0,8'hFF);
        do_reset();
        run = 1'b1;
        wait_retire(c);
        @(negedge clock);
        check("goto_pc", 32'(pc), 32'hFF);
        wait_retire(c);
        run = 1'b0;
        @(negedge clock);
        check("wrap_pc", 32'(pc), 32'h00);

        // Slow memory: request held with stable address, then reset mid-wait.
        clear_mem();
        mem[0] = enc(VAL,1,8'h33); mem[1] = enc(VAL,2,8'h44);
        do_reset();
        run = 1'b1;
        wait_retire(c);
        auto_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            check($sformatf("wait_req_%0d", i), {23'd0, imem_req, imem_addr}, {23'd0, 1'b1, 8'd1});
        end
        manual_valid = 1'b1;
        @(negedge clock);
        manual_valid = 1'b0;
        wait_retire(c);
        @(negedge clock);
        peek_reg(3'd2, rv);
        check("slow_r2", 32'(rv), 32'h44);
        check("slow_pc", 32'(pc), 32'd2);
        check("slow_req", 32'(imem_req), 32'd1);
        reset = 1'b1;
        @(negedge clock);
        check("mid_rst_pc", 32'(pc), 32'd0);
        check("mid_rst_req", 32'(imem_req), 32'd0);
        reset = 1'b0;
        run = 1'b0;
        manual_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            if (i == 1) manual_valid = 1'b0;
            check($sformatf("stray_valid_%0d", i), {30'd0, instr_retired, imem_req}, 32'd0);
        end
        peek_reg(3'd1, rv);
        check("stray_r1", 32'(rv), 32'd0);
        check("stray_pc", 32'(pc), 32'd0);
        auto_valid = 1'b1;

        check("illegal_without_retire", 32'(n_ill_orphan), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/jac_control_unit.md
Name: jac_control_unit

Overview:
- Instruction sequencer that sits directly upstream of the ALU in the Jac1-8 core.
- Fetches 16-bit instruction words from program memory over a req/valid handshake and decodes them.
- Reads an internal 8x8 register file, drives the combinational ALU inputs, and writes the ALU result and status back.
- Resolves program-flow opcodes (GOTO/IFZ/IFNZ/IFEQ/IFST/IFGT) against the latched status and the register contents.

Parameters:
DataWidth, 8, data and register width
NumOpCodeBits, 5, opcode field width
ParamBits, 8, parameter/immediate width; also the PC width
NumStatusBits, 3, status width (bit0 Carry, bit1 Underflow, bit2 Zero)
NumRegs, 8, register file depth (index width 3)

Ports:
clock  in  1  system clock, rising edge
reset  in  1  synchronous, active-high reset
run  in  1  1 = sequencer may start new fetches
imem_req  out  1  fetch request, held until imem_valid
imem_addr  out  8  fetch address (= pc)
imem_data  in  16  instruction word: [15:11] opcode, [10:8] rd, [7:0] param
imem_valid  in  1  imem_data valid this cycle
alu_opcode  out  5  to ALU opcode
alu_operand1  out  8  r[rd]
alu_operand2  out  8  r[param[2:0]]
alu_param  out  8  param field
alu_result  in  8  ALU result (combinational)
alu_status  in  3  ALU status (combinational)
status_q  out  3  latched status register
pc  out  8  program counter
instr_retired  out  1  one-cycle pulse at the end of EXECUTE
illegal_op  out  1  one-cycle pulse when a reserved opcode retires
dbg_sel  in  3  debug register select
dbg_data  out  8  r[dbg_sel], combinational

Behaviour:
- Reset: pc=0, status_q=000, all registers r0..r7=0, state=FETCH, imem_req=0, alu_* outputs=0, instr_retired=0, illegal_op=0.
- Reset takes effect at the next edge from any state; a pending fetch is abandoned and a late imem_valid is ignored.

State machine:
- FETCH:
  - imem_req = run.
  - When imem_req=1 and imem_valid=1, latch imem_data and go to DECODE.
  - imem_valid while imem_req=0 is ignored.
  - imem_addr = pc throughout.
- DECODE (1 cycle):
  - Register alu_opcode=opcode, alu_operand1=r[rd], alu_operand2=r[param[2:0]], alu_param=param.
  - Go to EXECUTE.
- EXECUTE (1 cycle):
  - alu_* stay stable.
  - At the clock edge, commit per opcode (below), pulse instr_retired, return to FETCH.
- Minimum latency is 3 cycles per instruction (FETCH with immediate valid, DECODE, EXECUTE).
- A run deassert mid-instruction completes that instruction; the block then idles in FETCH with imem_req=0.
- alu_* hold their last values while in FETCH.

Commit rules (default pc <= pc+1, 8-bit wrap 255 -> 0):
- ADD, SUB, AND, OR, NOT, XOR, SHL, SHR: r[rd] <= alu_result; status_q <= alu_status.
- VAL: r[rd] <= param; status unchanged.
- NOP: no register or status change.
- GOTO: pc <= param.
- IFZ: pc <= param if status_q[2]=1, else pc+1.
- IFNZ: pc <= param if status_q[2]=0, else pc+1.
- IFEQ: branch if r[rd] == r[0] (unsigned compare).
- IFST: branch if r[rd] < r[0] (unsigned compare).
- IFGT: branch if r[rd] > r[0] (unsigned compare).
- Branches never modify registers or status_q.
- Reserved opcodes (01010–01111, 10110–11111): behave as NOP (pc+1) and pulse illegal_op with instr_retired.

Boundary conditions:
- rd equal to the operand2 index is legal; both ALU operands read the pre-write value.
- dbg_data reflects a register write from the cycle after the commit edge.

Test Plan:
- Reset, run=1, zero-wait memory. Program: VAL r1,5; VAL r2,3; ADD r1,src r2 (param=2) -> r1=8, status_q=000, instr_retired pulses every 3 cycles, pc=3.
- VAL r3,0x0F; VAL r4,0xF0; AND r3,src r4 -> r3=0x00, status_q=100. Then IFZ 0x40 -> pc=0x40. IFNZ at that point -> pc+1.
- GOTO 0xFF, then NOP at 0xFF -> pc wraps to 0x00.
- VAL r0,7; VAL r5,7; IFEQ r5,0x20 -> pc=0x20. VAL r5,9; IFGT r5,0x30 -> taken. IFST r5,0x50 -> not taken.
- Opcode 01010 -> illegal_op and instr_retired high together for exactly 1 cycle; registers and status unchanged; pc+1.
- imem_valid delayed 4 cycles: imem_req held high with a stable imem_addr. Assert reset during that wait -> pc=0, imem_req=0 next cycle; a subsequent stray imem_valid is ignored.
